result_checker: RTL and testbench
=================================

# result_checker

End-of-program self-check engine for the pipelined CPU. It watches the fetched instruction stream for the halt sentinel and lets the pipeline drain for a programmable number of cycles. It then scans data memory and the register file in sequence, comparing each word against a golden image. It reports error count, first failing index, pass/fail and timeout in hardware, replacing bench-side polling.

## Interface
Parameters:
- DATA_W, 32, word width of instruction, DUT and golden data
- MEM_WORDS, 32, data-memory words checked (indices 0..MEM_WORDS-1)
- REG_WORDS, 32, register-file words checked (indices MEM_WORDS..MEM_WORDS+REG_WORDS-1)
- DRAIN_CYCLES, 5, cycles waited after halt detect before scan; 0 is legal
- HALT_WORD, 32'hFFFFFFFF, instruction pattern that signals program end
- TIMEOUT, 200, run cycles allowed before a halt must be seen; must be ≥1
- IDX_W, 7, index width; must satisfy 2^IDX_W > MEM_WORDS+REG_WORDS

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous reset, active-low
- instr_i  in  DATA_W  instruction fetched this cycle
- instr_vld_i  in  1  instr_i is valid
- chk_sel_o  out  1  0 = data memory, 1 = register file
- chk_addr_o  out  IDX_W  word address within the selected store
- chk_rd_o  out  1  read strobe; dut_data_i is valid exactly one cycle later
- dut_data_i  in  DATA_W  DUT read data
- gold_addr_o  out  IDX_W  golden-image index (0..MEM_WORDS+REG_WORDS-1)
- gold_data_i  in  DATA_W  golden data, same one-cycle latency as dut_data_i
- cmp_vld_o  out  1  one compare result is presented this cycle
- cmp_idx_o  out  IDX_W  index of the presented compare
- cmp_mismatch_o  out  1  the presented compare failed
- err_cnt_o  out  IDX_W  running mismatch count, saturating at all-ones
- first_err_vld_o  out  1  at least one mismatch has been recorded
- first_err_idx_o  out  IDX_W  index of the first mismatch
- done_o  out  1  check complete; sticky until reset
- pass_o  out  1  done_o and no mismatch and no timeout
- timeout_o  out  1  TIMEOUT expired without a halt being seen

## Operation
- FSM states: RUN, DRAIN, SCAN, DONE. Reset (rst_i=0 at an edge) forces RUN and clears all counters.
- RUN: the cycle counter increments each cycle.
  - On instr_vld_i=1 and instr_i==HALT_WORD: go to DRAIN (or straight to SCAN if DRAIN_CYCLES=0).
  - If the counter reaches TIMEOUT-1 with no halt: go to DONE with timeout_o=1 and no scan.
  - If halt and timeout occur in the same cycle, halt wins.
- DRAIN: stays exactly DRAIN_CYCLES cycles, then goes to SCAN. Instructions are ignored, including further halt words.
- SCAN: issues one read per cycle for idx = 0..N-1, where N = MEM_WORDS+REG_WORDS.
  - idx < MEM_WORDS: chk_sel_o=0, chk_addr_o=idx.
  - Otherwise: chk_sel_o=1, chk_addr_o=idx-MEM_WORDS.
  - gold_addr_o=idx. chk_rd_o=1 only while issuing.
- Compare: one cycle after issue, compute the full-width inequality dut_data_i != gold_data_i and register the result into cmp_*.
  - On a mismatch, err_cnt_o increments (saturating).
  - On the first mismatch, capture first_err_idx_o and set first_err_vld_o.
- DONE: entered once the last compare is registered. done_o=1 and pass_o = (err_cnt_o==0 && !timeout_o). Holds until reset; the stream is ignored.
- Reset values: every output is 0, including chk_*, gold_addr_o, err_cnt_o, first_err_*, done_o, pass_o and timeout_o.
- Reset asserted in any state, mid-scan included, aborts immediately. Partial results are discarded.

## Timing
- Halt is sampled at the edge ending cycle h. DRAIN then occupies cycles h+1..h+DRAIN_CYCLES.
- Read for idx k is issued in cycle h+DRAIN_CYCLES+1+k.
- The result for idx k is visible on cmp_* and err_cnt_o in cycle h+DRAIN_CYCLES+3+k.
- done_o and pass_o first go high together with the last cmp_vld_o, in cycle h+DRAIN_CYCLES+N+2.
- Timeout: cycle 0 is the first cycle after reset release. timeout_o and done_o go high in cycle TIMEOUT.
- Throughput: one compare per cycle, no stalls. The DUT and golden ports must meet the fixed one-cycle latency.

## Test plan
- All match, defaults (N=64, D=5), halt at cycle 10:
  - cmp_vld_o high in cycles 18..81; done_o=1 and pass_o=1 at cycle 81; err_cnt_o=0; first_err_vld_o=0.
- Golden differs at idx 3 (mem word 3) and idx 40 (reg 8), halt at cycle 10:
  - cmp_mismatch_o=1 at cycles 21 and 58; err_cnt_o=2; first_err_idx_o=3; pass_o=0.
  - chk_sel_o=1 and chk_addr_o=8 in cycle 56.
- No halt:
  - timeout_o=1 and done_o=1 at cycle 200; chk_rd_o never asserted; pass_o=0.
- Halt word with instr_vld_i=0 at cycle 5 and a valid halt at cycle 10; extra halt words at cycles 12 and 30:
  - Only the cycle-10 halt counts; timing identical to the first scenario.
- DRAIN_CYCLES=0, halt at cycle 4:
  - First read issued at cycle 5; done_o at cycle 70.
- Reset pulled low at cycle 40 of an active scan:
  - All outputs are 0 at cycle 41. After release, a new halt runs a complete, correct check.

Source files
------------

// File: rtl/result_checker.sv
// result_checker: end-of-program self-check engine for the pipelined CPU.
//
// The block waits for the halt sentinel on the fetch stream and lets the
// pipeline drain for DRAIN_CYCLES. It then reads every data-memory word and
// every register-file word, one per cycle, and compares each against the
// golden image. If no halt arrives within TIMEOUT cycles, it reports a timeout
// instead and skips the scan.
//
// Ports:
//   clk_i, rst_i        clock (rising edge) and synchronous active-low reset
//   instr_i/instr_vld_i fetched instruction stream, watched for HALT_WORD
//   chk_sel_o           0 = data memory, 1 = register file
//   chk_addr_o          word address inside the selected store
//   chk_rd_o            read strobe; dut_data_i is valid one cycle later
//   dut_data_i          DUT read data
//   gold_addr_o         flat golden-image index
//   gold_data_i         golden data, same one-cycle latency as dut_data_i
//   cmp_vld_o/idx/mismatch  per-word compare result, registered
//   err_cnt_o           saturating mismatch count
//   first_err_vld_o/idx first mismatch capture
//   done_o, pass_o, timeout_o  final status, sticky until reset
module result_checker #(
  parameter int                DATA_W       = 32,
  parameter int                MEM_WORDS    = 32,
  parameter int                REG_WORDS    = 32,
  parameter int                DRAIN_CYCLES = 5,
  parameter logic [DATA_W-1:0] HALT_WORD    = 32'hFFFF_FFFF,
  parameter int                TIMEOUT      = 200,
  parameter int                IDX_W        = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic              instr_vld_i,
  output logic              chk_sel_o,
  output logic [IDX_W-1:0]  chk_addr_o,
  output logic              chk_rd_o,
  input  logic [DATA_W-1:0] dut_data_i,
  output logic [IDX_W-1:0]  gold_addr_o,
  input  logic [DATA_W-1:0] gold_data_i,
  output logic              cmp_vld_o,
  output logic [IDX_W-1:0]  cmp_idx_o,
  output logic              cmp_mismatch_o,
  output logic [IDX_W-1:0]  err_cnt_o,
  output logic              first_err_vld_o,
  output logic [IDX_W-1:0]  first_err_idx_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o
);

  localparam int N_WORDS = MEM_WORDS + REG_WORDS;
  // Cycle counter only needs to reach TIMEOUT-1; drain counter DRAIN_CYCLES-1.
  localparam int CYC_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int DRN_W   = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Flat index -> {store select, address within store}.
  function automatic logic [IDX_W:0] map_idx(input logic [IDX_W-1:0] idx);
    logic             sel;
    logic [IDX_W-1:0] addr;
    sel = (idx >= IDX_W'(MEM_WORDS));
    if (sel) begin
      addr = idx - IDX_W'(MEM_WORDS);
    end else begin
      addr = idx;
    end
    return {sel, addr};
  endfunction

  // Mismatch counter increment that sticks at all-ones.
  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] cnt);
    if (cnt == {IDX_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + 1'b1;
    end
  endfunction

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             chk_rd_q, chk_rd_d;
  logic             chk_sel_q, chk_sel_d;
  logic [IDX_W-1:0] chk_addr_q, chk_addr_d;
  logic [IDX_W-1:0] gold_addr_q, gold_addr_d;
  // A read issued last cycle: its data is on the inputs this cycle.
  logic             pend_q, pend_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic             cmp_vld_q, cmp_vld_d;
  logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
  logic             cmp_mis_q, cmp_mis_d;
  logic [IDX_W-1:0] err_cnt_q, err_cnt_d;
  logic             ferr_vld_q, ferr_vld_d;
  logic [IDX_W-1:0] ferr_idx_q, ferr_idx_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;

  logic             halt_s;
  logic             mis_s;

  assign halt_s = instr_vld_i && (instr_i == HALT_WORD);
  assign mis_s  = (dut_data_i != gold_data_i);

  // Next-state and next-output computation for the check sequencer
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    drn_d       = drn_q;
    chk_rd_d    = 1'b0;
    chk_sel_d   = chk_sel_q;
    chk_addr_d  = chk_addr_q;
    gold_addr_d = gold_addr_q;
    pend_d      = chk_rd_q;
    pend_idx_d  = gold_addr_q;
    cmp_vld_d   = 1'b0;
    cmp_idx_d   = cmp_idx_q;
    cmp_mis_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    ferr_vld_d  = ferr_vld_q;
    ferr_idx_d  = ferr_idx_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_RUN: begin
        cyc_d = cyc_q + 1'b1;
        // Halt takes priority over a timeout in the same cycle.
        if (halt_s) begin
          if (DRAIN_CYCLES == 0) begin
            state_d                 = ST_SCAN;
            chk_rd_d                = 1'b1;
            gold_addr_d             = {IDX_W{1'b0}};
            {chk_sel_d, chk_addr_d} = map_idx({IDX_W{1'b0}});
          end else begin
            state_d = ST_DRAIN;
            drn_d   = {DRN_W{1'b0}};
          end
        end else if (cyc_q == CYC_W'(TIMEOUT - 1)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          pass_d    = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_DRAIN: begin
        if (drn_q == DRN_W'(DRAIN_CYCLES - 1)) begin
          state_d                 = ST_SCAN;
          chk_rd_d                = 1'b1;
          gold_addr_d             = {IDX_W{1'b0}};
          {chk_sel_d, chk_addr_d} = map_idx({IDX_W{1'b0}});
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end

      ST_SCAN: begin
        // Issue side: advance one index per cycle until the last word.
        if (chk_rd_q && (gold_addr_q != IDX_W'(N_WORDS - 1))) begin
          chk_rd_d                = 1'b1;
          gold_addr_d             = gold_addr_q + 1'b1;
          {chk_sel_d, chk_addr_d} = map_idx(gold_addr_q + 1'b1);
        end else begin
          chk_rd_d = 1'b0;
        end
        // Compare side: data for the read issued last cycle is present now.
        if (pend_q) begin
          cmp_vld_d = 1'b1;
          cmp_idx_d = pend_idx_q;
          cmp_mis_d = mis_s;
          if (mis_s) begin
            err_cnt_d = sat_inc(err_cnt_q);
            if (!ferr_vld_q) begin
              ferr_vld_d = 1'b1;
              ferr_idx_d = pend_idx_q;
            end else begin
              ferr_vld_d = ferr_vld_q;
            end
          end else begin
            err_cnt_d = err_cnt_q;
          end
          if (pend_idx_q == IDX_W'(N_WORDS - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == {IDX_W{1'b0}}) && !timeout_q;
          end else begin
            state_d = ST_SCAN;
          end
        end else begin
          cmp_vld_d = 1'b0;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_RUN;
      cyc_q       <= {CYC_W{1'b0}};
      drn_q       <= {DRN_W{1'b0}};
      chk_rd_q    <= 1'b0;
      chk_sel_q   <= 1'b0;
      chk_addr_q  <= {IDX_W{1'b0}};
      gold_addr_q <= {IDX_W{1'b0}};
      pend_q      <= 1'b0;
      pend_idx_q  <= {IDX_W{1'b0}};
      cmp_vld_q   <= 1'b0;
      cmp_idx_q   <= {IDX_W{1'b0}};
      cmp_mis_q   <= 1'b0;
      err_cnt_q   <= {IDX_W{1'b0}};
      ferr_vld_q  <= 1'b0;
      ferr_idx_q  <= {IDX_W{1'b0}};
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      drn_q       <= drn_d;
      chk_rd_q    <= chk_rd_d;
      chk_sel_q   <= chk_sel_d;
      chk_addr_q  <= chk_addr_d;
      gold_addr_q <= gold_addr_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_idx_q   <= cmp_idx_d;
      cmp_mis_q   <= cmp_mis_d;
      err_cnt_q   <= err_cnt_d;
      ferr_vld_q  <= ferr_vld_d;
      ferr_idx_q  <= ferr_idx_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  assign chk_rd_o        = chk_rd_q;
  assign chk_sel_o       = chk_sel_q;
  assign chk_addr_o      = chk_addr_q;
  assign gold_addr_o     = gold_addr_q;
  assign cmp_vld_o       = cmp_vld_q;
  assign cmp_idx_o       = cmp_idx_q;
  assign cmp_mismatch_o  = cmp_mis_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_vld_o = ferr_vld_q;
  assign first_err_idx_o = ferr_idx_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_result_checker.sv
// Testbench for result_checker: two instances (default drain, zero drain)
// share the instruction stream; each has its own registered store model.
module tb_result_checker;
  localparam int          MW   = 32;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] instr;
  logic        instr_vld;

  logic        a_sel, a_rd, a_cvld, a_cmis, a_fvld, a_done, a_pass, a_to;
  logic [6:0]  a_addr, a_gaddr, a_cidx, a_err, a_fidx;
  logic [31:0] a_dd, a_gd;
  logic        b_sel, b_rd, b_cvld, b_cmis, b_fvld, b_done, b_pass, b_to;
  logic [6:0]  b_addr, b_gaddr, b_cidx, b_err, b_fidx;
  logic [31:0] b_dd, b_gd;

  logic [31:0] dmem [128];
  logic [31:0] gmem [128];

  int checks = 0;
  int errors = 0;
  int cur;
  logic sel_b;

  // Observation state filled by the run task
  int first_vld, last_vld, vld_cnt, done_cyc, first_rd, rd_cnt;
  logic pass_at_done, to_at_done, probe_sel;
  logic [6:0] probe_addr, probe_gaddr;
  int mis_cyc [$];

  logic        o_sel, o_rd, o_cvld, o_cmis, o_fvld, o_done, o_pass, o_to;
  logic [6:0]  o_addr, o_gaddr, o_cidx, o_err, o_fidx;
  logic [42:0] o_all;

  result_checker dut_a (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr), .instr_vld_i(instr_vld),
    .chk_sel_o(a_sel), .chk_addr_o(a_addr), .chk_rd_o(a_rd), .dut_data_i(a_dd),
    .gold_addr_o(a_gaddr), .gold_data_i(a_gd), .cmp_vld_o(a_cvld),
    .cmp_idx_o(a_cidx), .cmp_mismatch_o(a_cmis), .err_cnt_o(a_err),
    .first_err_vld_o(a_fvld), .first_err_idx_o(a_fidx), .done_o(a_done),
    .pass_o(a_pass), .timeout_o(a_to)
  );

  result_checker #(.DRAIN_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr), .instr_vld_i(instr_vld),
    .chk_sel_o(b_sel), .chk_addr_o(b_addr), .chk_rd_o(b_rd), .dut_data_i(b_dd),
    .gold_addr_o(b_gaddr), .gold_data_i(b_gd), .cmp_vld_o(b_cvld),
    .cmp_idx_o(b_cidx), .cmp_mismatch_o(b_cmis), .err_cnt_o(b_err),
    .first_err_vld_o(b_fvld), .first_err_idx_o(b_fidx), .done_o(b_done),
    .pass_o(b_pass), .timeout_o(b_to)
  );

  always #5 clk = ~clk;

  // Store models: one-cycle registered read for both instances
  always @(posedge clk) begin
    if (a_rd) begin
      a_dd <= dmem[a_addr + (a_sel ? 7'd32 : 7'd0)];
      a_gd <= gmem[a_gaddr];
    end
    if (b_rd) begin
      b_dd <= dmem[b_addr + (b_sel ? 7'd32 : 7'd0)];
      b_gd <= gmem[b_gaddr];
    end
  end

  // Pick which instance is being observed
  always_comb begin
    o_sel   = sel_b ? b_sel   : a_sel;
    o_rd    = sel_b ? b_rd    : a_rd;
    o_addr  = sel_b ? b_addr  : a_addr;
    o_gaddr = sel_b ? b_gaddr : a_gaddr;
    o_cvld  = sel_b ? b_cvld  : a_cvld;
    o_cidx  = sel_b ? b_cidx  : a_cidx;
    o_cmis  = sel_b ? b_cmis  : a_cmis;
    o_err   = sel_b ? b_err   : a_err;
    o_fvld  = sel_b ? b_fvld  : a_fvld;
    o_fidx  = sel_b ? b_fidx  : a_fidx;
    o_done  = sel_b ? b_done  : a_done;
    o_pass  = sel_b ? b_pass  : a_pass;
    o_to    = sel_b ? b_to    : a_to;
    o_all   = {o_rd, o_sel, o_addr, o_gaddr, o_cvld, o_cidx, o_cmis, o_err,
               o_fvld, o_fidx, o_done, o_pass, o_to};
  end

  task automatic init_mem();
    for (int i = 0; i < 128; i++) begin
      dmem[i] = {8'hA5, 8'(i), 8'(~i), 8'(i * 7)};
      gmem[i] = dmem[i];
    end
  endtask

  // Reset edge, then release: the caller continues in cycle 0
  task automatic do_reset();
    rst_i = 1'b0;
    instr_vld = 1'b0;
    instr = 32'h0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    cur = 0;
  endtask

  // Drive the instruction stream for ncyc cycles and record what happens
  task automatic run(input int halt_at, input int nv_at, input int xa,
                     input int xb, input int probe, input int ncyc);
    first_vld = -1; last_vld = -1; vld_cnt = 0; done_cyc = -1;
    first_rd = -1; rd_cnt = 0; pass_at_done = 1'b0; to_at_done = 1'b0;
    probe_sel = 1'b0; probe_addr = 7'd0; probe_gaddr = 7'd0;
    mis_cyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (c == halt_at || c == xa || c == xb) begin
        instr = HALT; instr_vld = 1'b1;
      end else if (c == nv_at) begin
        instr = HALT; instr_vld = 1'b0;
      end else begin
        instr = $urandom & 32'h7FFF_FFFF; instr_vld = 1'($urandom);
      end
      if (o_cvld) begin
        if (first_vld < 0) first_vld = c;
        last_vld = c;
        vld_cnt++;
        if (o_cmis) mis_cyc.push_back(c);
      end
      if (o_rd) begin
        if (first_rd < 0) first_rd = c;
        rd_cnt++;
      end
      if (o_done && done_cyc < 0) begin
        done_cyc = c; pass_at_done = o_pass; to_at_done = o_to;
      end
      if (c == probe) begin
        probe_sel = o_sel; probe_addr = o_addr; probe_gaddr = o_gaddr;
      end
      @(posedge clk); #1;
      cur++;
    end
  endtask

  task automatic test_reset();
    sel_b = 1'b0;
    rst_i = 1'b0;
    instr_vld = 1'b0;
    instr = 32'h0;
    @(posedge clk); #1;
    checks++; if (a_done !== 1'b0 || {a_rd, a_cvld, a_err} !== 9'd0) begin errors++; $display("FAIL reset_a got done=%b rd=%b vld=%b err=%0d required all 0", a_done, a_rd, a_cvld, a_err); end
    checks++; if (o_all !== 43'd0) begin errors++; $display("FAIL reset_all got %h required 0", o_all); end
    sel_b = 1'b1;
    checks++; if (o_all !== 43'd0) begin errors++; $display("FAIL reset_all_b got %h required 0", o_all); end
    sel_b = 1'b0;
  endtask

  task automatic test_all_match();
    sel_b = 1'b0;
    do_reset();
    run(10, -1, -1, -1, -1, 100);
    checks++; if (first_rd !== 16) begin errors++; $display("FAIL match_first_rd got %0d required 16", first_rd); end
    checks++; if (rd_cnt !== 64) begin errors++; $display("FAIL match_rd_cnt got %0d required 64", rd_cnt); end
    checks++; if (first_vld !== 18) begin errors++; $display("FAIL match_first_vld got %0d required 18", first_vld); end
    checks++; if (last_vld !== 81) begin errors++; $display("FAIL match_last_vld got %0d required 81", last_vld); end
    checks++; if (vld_cnt !== 64) begin errors++; $display("FAIL match_vld_cnt got %0d required 64", vld_cnt); end
    checks++; if (done_cyc !== 81) begin errors++; $display("FAIL match_done_cyc got %0d required 81", done_cyc); end
    checks++; if (pass_at_done !== 1'b1) begin errors++; $display("FAIL match_pass got %b required 1", pass_at_done); end
    checks++; if (o_err !== 7'd0 || o_fvld !== 1'b0) begin errors++; $display("FAIL match_err got cnt=%0d fvld=%b required 0/0", o_err, o_fvld); end
    checks++; if (mis_cyc.size() !== 0) begin errors++; $display("FAIL match_mis got %0d mismatches required 0", mis_cyc.size()); end
    checks++; if (o_cidx !== 7'd63 || o_to !== 1'b0) begin errors++; $display("FAIL match_tail got idx=%0d to=%b required 63/0", o_cidx, o_to); end
  endtask

  task automatic test_mismatch();
    sel_b = 1'b0;
    gmem[3]  = gmem[3] ^ 32'h0000_0001;
    gmem[40] = gmem[40] ^ 32'h8000_0000;
    do_reset();
    run(10, -1, -1, -1, 56, 100);
    checks++; if (mis_cyc.size() !== 2) begin errors++; $display("FAIL mis_count got %0d required 2", mis_cyc.size()); end
    if (mis_cyc.size() == 2) begin
      checks++; if (mis_cyc[0] !== 21 || mis_cyc[1] !== 58) begin errors++; $display("FAIL mis_cycles got %0d,%0d required 21,58", mis_cyc[0], mis_cyc[1]); end
    end
    checks++; if (probe_sel !== 1'b1 || probe_addr !== 7'd8 || probe_gaddr !== 7'd40) begin errors++; $display("FAIL mis_probe got sel=%b addr=%0d gaddr=%0d required 1/8/40", probe_sel, probe_addr, probe_gaddr); end
    checks++; if (o_err !== 7'd2) begin errors++; $display("FAIL mis_err_cnt got %0d required 2", o_err); end
    checks++; if (o_fvld !== 1'b1 || o_fidx !== 7'd3) begin errors++; $display("FAIL mis_first got vld=%b idx=%0d required 1/3", o_fvld, o_fidx); end
    checks++; if (done_cyc !== 81 || o_pass !== 1'b0) begin errors++; $display("FAIL mis_done got cyc=%0d pass=%b required 81/0", done_cyc, o_pass); end
    init_mem();
  endtask

  task automatic test_timeout();
    sel_b = 1'b0;
    do_reset();
    run(-1, -1, -1, -1, -1, 205);
    checks++; if (done_cyc !== 200) begin errors++; $display("FAIL to_done_cyc got %0d required 200", done_cyc); end
    checks++; if (to_at_done !== 1'b1) begin errors++; $display("FAIL to_flag got %b required 1", to_at_done); end
    checks++; if (rd_cnt !== 0 || vld_cnt !== 0) begin errors++; $display("FAIL to_no_scan got rd=%0d vld=%0d required 0/0", rd_cnt, vld_cnt); end
    checks++; if (o_pass !== 1'b0 || o_done !== 1'b1) begin errors++; $display("FAIL to_status got pass=%b done=%b required 0/1", o_pass, o_done); end
  endtask

  task automatic test_halt_filter();
    sel_b = 1'b0;
    do_reset();
    run(10, 5, 12, 30, -1, 100);
    checks++; if (first_rd !== 16 || rd_cnt !== 64) begin errors++; $display("FAIL filt_rd got first=%0d cnt=%0d required 16/64", first_rd, rd_cnt); end
    checks++; if (first_vld !== 18 || last_vld !== 81 || vld_cnt !== 64) begin errors++; $display("FAIL filt_vld got %0d..%0d n=%0d required 18..81 n=64", first_vld, last_vld, vld_cnt); end
    checks++; if (done_cyc !== 81 || pass_at_done !== 1'b1) begin errors++; $display("FAIL filt_done got cyc=%0d pass=%b required 81/1", done_cyc, pass_at_done); end
  endtask

  task automatic test_drain_zero();
    sel_b = 1'b1;
    do_reset();
    run(4, -1, -1, -1, -1, 80);
    checks++; if (first_rd !== 5) begin errors++; $display("FAIL d0_first_rd got %0d required 5", first_rd); end
    checks++; if (first_vld !== 7 || vld_cnt !== 64) begin errors++; $display("FAIL d0_vld got first=%0d n=%0d required 7/64", first_vld, vld_cnt); end
    checks++; if (done_cyc !== 70 || pass_at_done !== 1'b1) begin errors++; $display("FAIL d0_done got cyc=%0d pass=%b required 70/1", done_cyc, pass_at_done); end
    sel_b = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    sel_b = 1'b0;
    gmem[5] = gmem[5] ^ 32'h0001_0000;
    do_reset();
    run(10, -1, -1, -1, -1, 40);
    checks++; if (o_cvld !== 1'b1 || o_err !== 7'd1 || o_fidx !== 7'd5) begin errors++; $display("FAIL mid_partial got vld=%b err=%0d fidx=%0d required 1/1/5", o_cvld, o_err, o_fidx); end
    rst_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_all !== 43'd0) begin errors++; $display("FAIL mid_reset_all got %h required 0", o_all); end
    init_mem();
    rst_i = 1'b1;
    cur = 0;
    run(10, -1, -1, -1, -1, 90);
    checks++; if (done_cyc !== 81 || pass_at_done !== 1'b1) begin errors++; $display("FAIL mid_rerun_done got cyc=%0d pass=%b required 81/1", done_cyc, pass_at_done); end
    checks++; if (o_err !== 7'd0 || o_fvld !== 1'b0 || vld_cnt !== 64) begin errors++; $display("FAIL mid_rerun_err got err=%0d fvld=%b n=%0d required 0/0/64", o_err, o_fvld, vld_cnt); end
  endtask

  initial begin
    sel_b = 1'b0;
    rst_i = 1'b0;
    instr = 32'h0;
    instr_vld = 1'b0;
    init_mem();
    test_reset();
    test_all_match();
    test_mismatch();
    test_timeout();
    test_halt_filter();
    test_drain_zero();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
